// File: rtl/vram_responder_if.sv
// VRAM bus between the rasterizer's initiator port and a memory-side responder.
// One request at a time: the initiator holds every request field stable until ack.
interface vram_responder_if;
    logic        vram_sel_i;
    logic        vram_wr_i;
    logic [3:0]  vram_mask_i;
    logic [31:0] vram_addr_i;
    logic [15:0] vram_data_i;
    logic        vram_ack_o;
    logic [15:0] vram_data_o;

    modport master (
        output vram_sel_i, vram_wr_i, vram_mask_i, vram_addr_i, vram_data_i,
        input  vram_ack_o, vram_data_o
    );

    modport slave (
        input  vram_sel_i, vram_wr_i, vram_mask_i, vram_addr_i, vram_data_i,
        output vram_ack_o, vram_data_o
    );
endinterface

// File: rtl/vram_responder.sv
// Memory-side end of the VRAM bus: 16-bit word array with programmable-latency
// request service and an independent one-cycle scan-out read port.
module vram_responder #(
    parameter int DEPTH   = 76800,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_i,
    vram_responder_if.slave   vram,
    input  logic              stall_i,
    input  logic [31:0]       scan_addr_i,
    output logic [15:0]       scan_data_o
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [3:0]  mask_q;
    logic [31:0] addr_q;
    logic [15:0] data_q;

    logic [15:0] mem [DEPTH];

    logic        commit;
    logic        cur_wr;
    logic [3:0]  cur_mask;
    logic [31:0] cur_addr;
    logic [15:0] cur_data;
    logic        cur_in_range;
    logic        scan_in_range;
    logic        mem_we;

    function automatic logic [15:0] merge_nibbles(input logic [15:0] old_word,
                                                  input logic [15:0] new_word,
                                                  input logic [3:0]  mask);
        logic [15:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[4*i +: 4] = new_word[4*i +: 4];
        end
        return res;
    endfunction

    // At LATENCY=1 the ACK-entry edge is the capture edge, so the live bus fields
    // are used directly; otherwise only the captured copies are used.
    always_comb begin
        cur_wr   = wr_q;
        cur_mask = mask_q;
        cur_addr = addr_q;
        cur_data = data_q;
        commit   = 1'b0;
        if (state == IDLE) begin
            cur_wr   = vram.vram_wr_i;
            cur_mask = vram.vram_mask_i;
            cur_addr = vram.vram_addr_i;
            cur_data = vram.vram_data_i;
            commit   = vram.vram_sel_i && (LATENCY == 1);
        end else if (state == WAIT) begin
            commit   = !stall_i && (cnt == 4'd1);
        end
        cur_in_range  = cur_addr < DEPTH_W;
        scan_in_range = scan_addr_i < DEPTH_W;
        mem_we        = commit && cur_wr && cur_in_range && !reset_i;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[cur_addr[AW-1:0]] <= merge_nibbles(mem[cur_addr[AW-1:0]], cur_data, cur_mask);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            wr_q             <= 1'b0;
            mask_q           <= 4'd0;
            addr_q           <= 32'd0;
            data_q           <= 16'd0;
            vram.vram_ack_o  <= 1'b0;
            vram.vram_data_o <= 16'h0000;
            scan_data_o      <= 16'h0000;
        end else begin
            vram.vram_ack_o <= commit;
            // Non-blocking read of the array gives read-before-write on collisions.
            scan_data_o     <= scan_in_range ? mem[scan_addr_i[AW-1:0]] : 16'h0000;
            if (commit && !cur_wr)
                vram.vram_data_o <= cur_in_range ? mem[cur_addr[AW-1:0]] : 16'h0000;

            case (state)
                IDLE: begin
                    if (vram.vram_sel_i) begin
                        wr_q   <= vram.vram_wr_i;
                        mask_q <= vram.vram_mask_i;
                        addr_q <= vram.vram_addr_i;
                        data_q <= vram.vram_data_i;
                        cnt    <= CNT_INIT;
                        state  <= (LATENCY == 1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!stall_i) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_responder.sv
// Scoreboarded bench for vram_responder: directed bus cases, randomized traffic with
// random stalls against a word-array model, back-to-back at LATENCY=1, scan-port checks.
module tb_vram_responder;
    localparam int DEPTH = 76800;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, stall1;
    logic [31:0] scan_addr, scan_addr1;
    logic [15:0] scan_data, scan_data1;

    always #5 clk = ~clk;

    vram_responder_if vif();
    vram_responder_if vif1();

    vram_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset_i(rst), .vram(vif), .stall_i(stall),
        .scan_addr_i(scan_addr), .scan_data_o(scan_data)
    );

    vram_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset_i(rst), .vram(vif1), .stall_i(stall1),
        .scan_addr_i(scan_addr1), .scan_data_o(scan_data1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          wr;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_ack;

    logic [15:0] model [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [31:0] a);
        if (a >= 32'(DEPTH)) return 16'h0000;
        if (model.exists(a)) return model[a];
        return 16'h0000;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [15:0] d, input logic [3:0] m);
        logic [15:0] old_w, em;
        if (a >= 32'(DEPTH)) return;
        old_w = model.exists(a) ? model[a] : 16'h0000;
        em = {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
        model[a] = (old_w & ~em) | (d & em);
    endfunction

    // Monitor: every ack pops one expectation; reads compare the returned word.
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
        end else begin
            if (vif.vram_ack_o) begin
                check("ack_width", {31'd0, prev_ack}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack with empty queue at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.wr) check("rd_data", vif.vram_data_o, mon_e.d);
                end
            end
            prev_ack = vif.vram_ack_o;
        end
    end

    // smode: 0 = no stall, 1 = random stall, 2 = stall for the first 3 WAIT edges.
    task automatic req(input bit wr, input logic [3:0] mask, input logic [31:0] addr,
                       input logic [15:0] data, input int smode, output int lat);
        int rem, nst;
        bit s;
        exp_t e;
        @(posedge clk); #1;
        e.wr = wr;
        e.d  = wr ? 16'h0000 : model_rd(addr);
        exp_q.push_back(e);
        vif.vram_sel_i  = 1'b1;
        vif.vram_wr_i   = wr;
        vif.vram_mask_i = mask;
        vif.vram_addr_i = addr;
        vif.vram_data_i = data;
        stall = 1'b0;
        @(posedge clk); #1;
        vif.vram_sel_i  = 1'b0;
        vif.vram_wr_i   = 1'($urandom);
        vif.vram_mask_i = 4'($urandom);
        vif.vram_addr_i = $urandom_range(0, 15);
        vif.vram_data_i = 16'($urandom);
        rem = LAT - 1;
        lat = 1;
        nst = 0;
        while (rem != 0 && lat < 64) begin
            check("early_ack", {31'd0, vif.vram_ack_o}, 32'd0);
            if (smode == 1)      s = 1'($urandom_range(0, 1));
            else if (smode == 2) s = (nst < 3);
            else                 s = 1'b0;
            stall = s;
            if (s) nst++;
            @(posedge clk); #1;
            if (!s) rem--;
            lat++;
        end
        stall = 1'b0;
        check("ack_due", {31'd0, vif.vram_ack_o}, 32'd1);
        if (wr && vif.vram_ack_o) model_wr(addr, data, mask);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int e_cnt, n;
        int ack_edge [4];
        logic [31:0] a;
        logic [15:0] b2b_data [4];

        rst = 1'b1;
        stall = 1'b0; stall1 = 1'b0;
        scan_addr = 32'd0; scan_addr1 = 32'd0;
        vif.vram_sel_i = 1'b0; vif.vram_wr_i = 1'b0; vif.vram_mask_i = 4'h0;
        vif.vram_addr_i = 32'd0; vif.vram_data_i = 16'h0;
        vif1.vram_sel_i = 1'b0; vif1.vram_wr_i = 1'b0; vif1.vram_mask_i = 4'h0;
        vif1.vram_addr_i = 32'd0; vif1.vram_data_i = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ack",   {31'd0, vif.vram_ack_o}, 32'd0);
        check("rst_rdata", vif.vram_data_o, 32'h0);
        check("rst_scan",  scan_data, 32'h0);
        check("rst_ack1",  {31'd0, vif1.vram_ack_o}, 32'd0);
        check("rst_scan1", scan_data1, 32'h0);

        // Basic write/read at LATENCY=2
        req(1'b1, 4'hF, 32'd5, 16'hABCD, 0, lat);
        check("wr_latency", lat, LAT);
        req(1'b0, 4'hF, 32'd5, 16'h0000, 0, lat);
        check("rd_latency", lat, LAT);
        check("rd_addr5", vif.vram_data_o, 32'hABCD);

        // Masked write
        req(1'b1, 4'hF, 32'd10, 16'h1234, 0, lat);
        req(1'b1, 4'b0101, 32'd10, 16'hFFFF, 0, lat);
        req(1'b0, 4'hF, 32'd10, 16'h0000, 0, lat);
        check("mask_merge", vif.vram_data_o, 32'h1F3F);

        // Zero mask leaves the word alone
        req(1'b1, 4'h0, 32'd5, 16'h0000, 0, lat);
        req(1'b0, 4'hF, 32'd5, 16'h0000, 0, lat);
        check("mask_zero", vif.vram_data_o, 32'hABCD);

        // Out-of-range addresses
        req(1'b1, 4'hF, 32'd0, 16'h0A0A, 0, lat);
        req(1'b1, 4'hF, 32'd76799, 16'h7777, 0, lat);
        req(1'b1, 4'hF, 32'd76800, 16'hDEAD, 0, lat);
        req(1'b1, 4'hF, 32'hFFFF_FFFF, 16'hBEEF, 0, lat);
        req(1'b0, 4'hF, 32'd76800, 16'h0, 0, lat);
        check("oob_rd_76800", vif.vram_data_o, 32'h0);
        req(1'b0, 4'hF, 32'd76799, 16'h0, 0, lat);
        check("last_word", vif.vram_data_o, 32'h7777);
        req(1'b0, 4'hF, 32'hFFFF_FFFF, 16'h0, 0, lat);
        check("oob_rd_max", vif.vram_data_o, 32'h0);
        req(1'b0, 4'hF, 32'd0, 16'h0, 0, lat);
        check("first_word", vif.vram_data_o, 32'h0A0A);

        // Stall during WAIT for 3 cycles
        req(1'b1, 4'hF, 32'd30, 16'h3333, 2, lat);
        check("stall_latency", lat, LAT + 3);

        // Reset in the middle of a write: abandoned
        req(1'b1, 4'hF, 32'd40, 16'h4040, 0, lat);
        scan_addr = 32'd40;
        @(posedge clk); #1;
        vif.vram_sel_i = 1'b1; vif.vram_wr_i = 1'b1; vif.vram_mask_i = 4'hF;
        vif.vram_addr_i = 32'd40; vif.vram_data_i = 16'hBAD0;
        @(posedge clk); #1;
        vif.vram_sel_i = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_ack",   {31'd0, vif.vram_ack_o}, 32'd0);
        check("midrst_rdata", vif.vram_data_o, 32'h0);
        check("midrst_scan",  scan_data, 32'h0);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("no_ack_after_rst", {31'd0, vif.vram_ack_o}, 32'd0);
        end
        req(1'b0, 4'hF, 32'd40, 16'h0, 0, lat);
        check("rst_word_kept", vif.vram_data_o, 32'h4040);

        // Scan collision: read-before-write
        req(1'b1, 4'hF, 32'd20, 16'h0001, 0, lat);
        scan_addr = 32'd20;
        req(1'b1, 4'hF, 32'd20, 16'h5555, 0, lat);
        check("scan_collide_old", scan_data, 32'h0001);
        @(posedge clk); #1;
        check("scan_collide_new", scan_data, 32'h5555);
        scan_addr = 32'd76800;
        @(posedge clk); #1;
        check("scan_oob", scan_data, 32'h0);
        scan_addr = 32'd5;
        @(posedge clk); #1;
        check("scan_addr5", scan_data, 32'hABCD);

        // Randomized traffic over a small window plus out-of-range addresses
        for (int i = 0; i < 16; i++) req(1'b1, 4'hF, 32'(i), 16'($urandom), 0, lat);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = $urandom_range(0, 1) ? 32'(DEPTH + $urandom_range(0, 3)) : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            else
                a = $urandom_range(0, 15);
            req(1'($urandom), 4'($urandom), a, 16'($urandom), 1, lat);
        end
        for (int i = 0; i < 16; i++) begin
            scan_addr = 32'(i);
            @(posedge clk); #1;
            check("scan_sweep", scan_data, {16'h0, model_rd(32'(i))});
        end

        // Back-to-back writes with sel held high at LATENCY=1
        for (int j = 0; j < 4; j++) b2b_data[j] = 16'h1000 * 16'(j + 1) + 16'h0011;
        @(posedge clk); #1;
        vif1.vram_sel_i = 1'b1; vif1.vram_wr_i = 1'b1; vif1.vram_mask_i = 4'hF;
        vif1.vram_addr_i = 32'd100; vif1.vram_data_i = b2b_data[0];
        @(posedge clk); #1;
        e_cnt = 0;
        n = 0;
        while (n < 4 && e_cnt < 20) begin
            if (vif1.vram_ack_o) begin
                ack_edge[n] = e_cnt;
                n++;
                if (n < 4) begin
                    vif1.vram_addr_i = 32'(100 + n);
                    vif1.vram_data_i = b2b_data[n];
                end else begin
                    vif1.vram_sel_i = 1'b0;
                end
            end
            @(posedge clk); #1;
            e_cnt++;
        end
        vif1.vram_sel_i = 1'b0;
        check("b2b_ack_count", n, 4);
        for (int j = 0; j < 4; j++) begin
            if (j < n) check("b2b_ack_time", ack_edge[j], 2 * j);
        end
        for (int j = 0; j < 4; j++) begin
            scan_addr1 = 32'(100 + j);
            @(posedge clk); #1;
            check("b2b_stored", scan_data1, {16'h0, b2b_data[j]});
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_responder.md
# vram_responder

Simulation/FPGA VRAM responder: the memory-side end of the graphite VRAM bus. It accepts single-word read/write requests from the rasterizer's VRAM initiator port, services them from an internal 16-bit word array after a programmable latency, and returns a one-cycle acknowledge. A second, independent synchronous read port serves display scan-out from the same array, so rasterizer output can be checked or displayed without external memory.

## Interface
- DEPTH, 76800: array size in 16-bit words (320x240); valid addresses 0..DEPTH-1
- LATENCY, 2: cycles from request capture to ack; legal range 1..15
- clk  in  1  system clock, all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- vram_sel_i  in  1  request valid; held with all request fields stable until ack
- vram_wr_i  in  1  1 = write, 0 = read
- vram_mask_i  in  4  nibble write enables; bit i enables data[4i+3:4i]
- vram_addr_i  in  32  word address
- vram_data_i  in  16  write data (ARGB4444)
- vram_ack_o  out  1  one-cycle completion pulse
- vram_data_o  out  16  read data, valid in ack cycle of a read, held until next read ack
- stall_i  in  1  freezes the latency counter while high (contention model)
- scan_addr_i  in  32  scan-out word address
- scan_data_o  out  16  scan-out data, one cycle after scan_addr_i

## Operation
- State machine: IDLE, WAIT, ACK.
- IDLE: if vram_sel_i=1, capture wr/mask/addr/data into request registers; load counter with LATENCY-1; go to ACK if LATENCY=1, else WAIT.
- WAIT: if stall_i=0, decrement counter; when counter is 1 and stall_i=0, go to ACK. stall_i=1 holds state and counter.
- On the edge entering ACK: write commits (masked nibbles only) or read data loads into vram_data_o from the captured address.
- ACK: vram_ack_o=1 for exactly one cycle; next state IDLE unconditionally; vram_sel_i ignored during ACK.
- Back-to-back: initiator may keep vram_sel_i high after ack; next request is captured in the IDLE cycle following ACK (minimum 2-cycle request spacing at LATENCY=1).
- Out-of-range (vram_addr_i >= DEPTH, full 32-bit compare): write dropped, read returns 16'h0000; still acknowledged with normal latency.
- mask=4'b0000 write: acked, array unchanged.
- Only captured fields are used; changes on vram_*_i after capture have no effect.
- Scan port: scan_data_o <= array[scan_addr_i] every cycle, independent of the FSM; out-of-range returns 16'h0000.
- Collision: scan read of the address being written on the same edge returns old data (read-before-write).

## Timing
- Reset values: state IDLE, vram_ack_o=0, vram_data_o=16'h0000, scan_data_o=16'h0000, counter 0; array contents not reset.
- Reset asserted mid-transaction: in-flight request abandoned, no ack, no write if reset precedes the ACK-entry edge.
- Request sampled at edge T (IDLE, sel=1) -> vram_ack_o high during cycle T+LATENCY (plus stalled cycles) -> IDLE at T+LATENCY+1.
- vram_data_o changes only on ACK-entry edge of a read.
- Scan latency fixed at 1 cycle.

## Test plan
- Reset, then write addr 5 data 16'hABCD mask 4'hF, LATENCY=2 -> ack exactly 2 cycles after capture, single cycle; read addr 5 -> vram_data_o=16'hABCD in ack cycle.
- Pre-fill addr 10 with 16'h1234, write 16'hFFFF mask 4'b0101 -> read returns 16'h1F3F.
- Write to addr 76800 and addr 32'hFFFF_FFFF -> both acked; read returns 16'h0000; addr 0 and 76799 unaffected.
- sel held high for 4 back-to-back writes at LATENCY=1 -> acks at T+1, T+3, T+5, T+7; all four words stored.
- stall_i high for 3 cycles during WAIT at LATENCY=3 -> ack delayed to T+6; assert reset_i during a second request's WAIT -> no ack, target word unchanged, outputs zero.
- Scan port reads addr 20 while rasterizer writes 16'h5555 over 16'h0001 on same edge -> scan_data_o=16'h0001, next scan read 16'h5555.
